// File: rtl/uart_cmd_defs.sv
// Shared constants for the UART command framer: packet layout, byte indices, FSM states.
package uart_cmd_defs;

   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
   localparam int         PKT_LEN      = 10;

   typedef logic [$clog2(PKT_LEN)-1:0] idx_t;

   localparam idx_t IDX_SYNC   = 4'd0;
   localparam idx_t IDX_OP     = 4'd1;
   localparam idx_t IDX_PARAMS = 4'd2;
   localparam idx_t IDX_REGS1  = 4'd3;
   localparam idx_t IDX_REGS2  = 4'd4;
   localparam idx_t IDX_O1L    = 4'd5;
   localparam idx_t IDX_O1H    = 4'd6;
   localparam idx_t IDX_O2L    = 4'd7;
   localparam idx_t IDX_O2H    = 4'd8;
   localparam idx_t IDX_CHK    = 4'd9;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      CHECK,
      HOLD
   } state_t;

   typedef struct packed {
      logic [5:0]  op;
      logic [3:0]  params;
      logic [2:0]  a;
      logic [2:0]  b;
      logic [2:0]  y;
      logic [15:0] opnd1;
      logic [15:0] opnd2;
   } cmd_t;

endpackage

// File: rtl/uart_cmd_parser_timeout.sv
// Inter-byte idle counter; o_expire is asserted in the last allowed idle cycle
// unless a byte clears the counter in that same cycle.
module uart_cmd_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   localparam int W = $clog2(TIMEOUT_CYCLES + 1);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign o_expire = i_en && !i_clr && (r_cnt == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames the UART RX byte stream into 10-byte ALU command packets with XOR checksum.
// Optional inter-byte timeout when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_parser
   import uart_cmd_defs::*;
#(
   parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
`ifdef UART_CMD_TIMEOUT_EN
   , parameter int unsigned TIMEOUT_CYCLES = 1000000
`endif
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [7:0]  rxData,
   input  logic        rxReady,
   output logic        cmdValid,
   input  logic        cmdReady,
   output logic [5:0]  cmdOp,
   output logic [3:0]  cmdParams,
   output logic [2:0]  cmdA,
   output logic [2:0]  cmdB,
   output logic [2:0]  cmdY,
   output logic [15:0] cmdOpnd1,
   output logic [15:0] cmdOpnd2,
   output logic        errChecksum,
   output logic        errOverrun,
   output logic        errTimeout
);

   state_t     r_state, w_next;
   idx_t       r_idx;
   logic [7:0] r_chk;
   cmd_t       r_stage, r_cmd;
   logic       r_valid, r_err_chk, r_err_ovr, r_err_to;
   logic       w_start, w_collect, w_load, w_hs, w_abort;
   logic       w_err_chk, w_err_ovr, w_err_to, w_expire;

`ifdef UART_CMD_TIMEOUT_EN
   uart_cmd_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .i_clk    (CLK),
      .i_rst    (RST),
      .i_clr    (rxReady),
      .i_en     ((r_state == COLLECT) || (r_state == CHECK)),
      .o_expire (w_expire)
   );
`else
   assign w_expire = 1'b0;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_start   = 1'b0;
      w_collect = 1'b0;
      w_load    = 1'b0;
      w_hs      = 1'b0;
      w_err_chk = 1'b0;
      w_err_ovr = 1'b0;
      w_err_to  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (rxReady && (rxData == SYNC_BYTE)) begin
               w_start = 1'b1;
               w_next  = COLLECT;
            end
         end
         COLLECT: begin
            if (rxReady) begin
               w_collect = 1'b1;
               if (r_idx == IDX_O2H) w_next = CHECK;
            end else if (w_expire) begin
               w_err_to = 1'b1;
               w_next   = IDLE;
            end
         end
         CHECK: begin
            if (rxReady) begin
               if (rxData == r_chk) begin
                  w_load = 1'b1;
                  w_next = HOLD;
               end else begin
                  w_err_chk = 1'b1;
                  w_next    = IDLE;
               end
            end else if (w_expire) begin
               w_err_to = 1'b1;
               w_next   = IDLE;
            end
         end
         HOLD: begin
            // A byte landing on the handshake cycle is treated as if already idle.
            if (cmdReady) begin
               w_hs   = 1'b1;
               w_next = IDLE;
               if (rxReady && (rxData == SYNC_BYTE)) begin
                  w_start = 1'b1;
                  w_next  = COLLECT;
               end
            end else if (rxReady) begin
               w_err_ovr = 1'b1;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   assign w_abort = w_err_chk || w_err_to;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_idx     <= IDX_SYNC;
         r_chk     <= '0;
         r_stage   <= '0;
         r_cmd     <= '0;
         r_valid   <= 1'b0;
         r_err_chk <= 1'b0;
         r_err_ovr <= 1'b0;
         r_err_to  <= 1'b0;
      end else begin
         r_err_chk <= w_err_chk;
         r_err_ovr <= w_err_ovr;
         r_err_to  <= w_err_to;
         if (w_start) begin
            r_idx <= IDX_OP;
            r_chk <= '0;
         end else if (w_collect) begin
            r_chk <= r_chk ^ rxData;
            r_idx <= (r_idx == IDX_O2H) ? IDX_CHK : r_idx + idx_t'(1);
            case (r_idx)
               IDX_OP:     r_stage.op          <= rxData[5:0];
               IDX_PARAMS: r_stage.params      <= rxData[3:0];
               IDX_REGS1: begin
                  r_stage.a <= rxData[2:0];
                  r_stage.b <= rxData[5:3];
               end
               IDX_REGS2:  r_stage.y           <= rxData[2:0];
               IDX_O1L:    r_stage.opnd1[7:0]  <= rxData;
               IDX_O1H:    r_stage.opnd1[15:8] <= rxData;
               IDX_O2L:    r_stage.opnd2[7:0]  <= rxData;
               IDX_O2H:    r_stage.opnd2[15:8] <= rxData;
               default: ;
            endcase
         end else if (w_abort || w_load) begin
            r_idx <= IDX_SYNC;
         end
         if (w_load) begin
            r_cmd   <= r_stage;
            r_valid <= 1'b1;
         end else if (w_hs) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign cmdValid    = r_valid;
   assign cmdOp       = r_cmd.op;
   assign cmdParams   = r_cmd.params;
   assign cmdA        = r_cmd.a;
   assign cmdB        = r_cmd.b;
   assign cmdY        = r_cmd.y;
   assign cmdOpnd1    = r_cmd.opnd1;
   assign cmdOpnd2    = r_cmd.opnd2;
   assign errChecksum = r_err_chk;
   assign errOverrun  = r_err_ovr;
   assign errTimeout  = r_err_to;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser; timeout scenarios run when UART_CMD_TIMEOUT_EN is defined.
module tb_uart_cmd_parser;

   logic        CLK, RST, rxReady, cmdReady, cmdValid;
   logic [7:0]  rxData;
   logic [5:0]  cmdOp;
   logic [3:0]  cmdParams;
   logic [2:0]  cmdA, cmdB, cmdY;
   logic [15:0] cmdOpnd1, cmdOpnd2;
   logic        errChecksum, errOverrun, errTimeout;

   int checks = 0;
   int failures = 0;
   int n_chk = 0, n_ovr = 0, n_to = 0, n_rise = 0;
   logic prev_valid = 1'b0;

   localparam logic [79:0] PKT_A     = 80'hA5_01_00_08_02_34_12_01_00_2C;
   localparam logic [79:0] PKT_A_BAD = 80'hA5_01_00_08_02_34_12_01_00_2D;
   localparam logic [79:0] PKT_B     = 80'hA5_FF_FA_1E_FD_CD_AB_34_12_A6;
   localparam logic [79:0] PKT_C     = 80'hA5_01_00_08_02_A5_12_01_00_BD;
   localparam logic [50:0] EXP_A = {6'h01, 4'h0, 3'd0, 3'd1, 3'd2, 16'h1234, 16'h0001};
   localparam logic [50:0] EXP_B = {6'h3F, 4'hA, 3'd6, 3'd3, 3'd5, 16'hABCD, 16'h1234};
   localparam logic [50:0] EXP_C = {6'h01, 4'h0, 3'd0, 3'd1, 3'd2, 16'h12A5, 16'h0001};

   wire [50:0] w_cmd = {cmdOp, cmdParams, cmdA, cmdB, cmdY, cmdOpnd1, cmdOpnd2};
   wire [2:0]  w_errs = {errChecksum, errOverrun, errTimeout};

`ifdef UART_CMD_TIMEOUT_EN
   uart_cmd_parser #(.TIMEOUT_CYCLES(50)) dut (
`else
   uart_cmd_parser dut (
`endif
      .CLK(CLK), .RST(RST), .rxData(rxData), .rxReady(rxReady),
      .cmdValid(cmdValid), .cmdReady(cmdReady),
      .cmdOp(cmdOp), .cmdParams(cmdParams), .cmdA(cmdA), .cmdB(cmdB), .cmdY(cmdY),
      .cmdOpnd1(cmdOpnd1), .cmdOpnd2(cmdOpnd2),
      .errChecksum(errChecksum), .errOverrun(errOverrun), .errTimeout(errTimeout)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Pulse counters sampled well away from both clock edges.
   always begin
      @(posedge CLK);
      #2;
      if (errChecksum) n_chk = n_chk + 1;
      if (errOverrun)  n_ovr = n_ovr + 1;
      if (errTimeout)  n_to  = n_to + 1;
      if (cmdValid && !prev_valid) n_rise = n_rise + 1;
      prev_valid = cmdValid;
   end

   task automatic clear_counts();
      n_chk = 0; n_ovr = 0; n_to = 0; n_rise = 0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge CLK);
      rxData  = b;
      rxReady = 1'b1;
      @(negedge CLK);
      rxReady = 1'b0;
   endtask

   task automatic send_range(input logic [79:0] v, input int first, input int last);
      for (int i = first; i <= last; i++) send_byte(v[79-8*i -: 8]);
   endtask

   task automatic consume();
      @(negedge CLK);
      cmdReady = 1'b1;
      @(negedge CLK);
      cmdReady = 1'b0;
   endtask

   task automatic test_reset();
      #1 RST = 1'b1;
      repeat (2) @(negedge CLK);
      checks++;
      if (cmdValid !== 1'b0) begin
         failures++; $display("FAIL reset_valid: got %b expected 0", cmdValid);
      end
      checks++;
      if (w_cmd !== 51'd0) begin
         failures++; $display("FAIL reset_cmd: got %h expected 0", w_cmd);
      end
      checks++;
      if (w_errs !== 3'b000) begin
         failures++; $display("FAIL reset_errs: got %b expected 000", w_errs);
      end
      RST = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_good_packet();
      clear_counts();
      send_range(PKT_A, 0, 8);
      @(negedge CLK);
      rxData = 8'h2C; rxReady = 1'b1;
      checks++;
      if (cmdValid !== 1'b0) begin
         failures++; $display("FAIL good_valid_early: got %b expected 0", cmdValid);
      end
      @(negedge CLK);
      rxReady = 1'b0;
      checks++;
      if (cmdValid !== 1'b1) begin
         failures++; $display("FAIL good_valid_latency: got %b expected 1", cmdValid);
      end
      checks++;
      if (w_cmd !== EXP_A) begin
         failures++; $display("FAIL good_decode: got %h expected %h", w_cmd, EXP_A);
      end
      consume();
      checks++;
      if (cmdValid !== 1'b0) begin
         failures++; $display("FAIL good_valid_drop: got %b expected 0", cmdValid);
      end
      checks++;
      if ((n_chk + n_ovr + n_to) !== 0) begin
         failures++; $display("FAIL good_no_errs: got %0d pulses expected 0", n_chk + n_ovr + n_to);
      end
   endtask

   task automatic test_bad_checksum();
      clear_counts();
      send_range(PKT_A_BAD, 0, 9);
      repeat (3) @(negedge CLK);
      checks++;
      if (n_chk !== 1) begin
         failures++; $display("FAIL bad_chk_pulse: got %0d pulses expected 1", n_chk);
      end
      checks++;
      if (n_rise !== 0) begin
         failures++; $display("FAIL bad_chk_no_valid: got %0d rises expected 0", n_rise);
      end
      send_range(PKT_A, 0, 9);
      checks++;
      if (cmdValid !== 1'b1 || w_cmd !== EXP_A) begin
         failures++; $display("FAIL bad_chk_recover: got valid=%b cmd=%h expected 1 %h", cmdValid, w_cmd, EXP_A);
      end
      consume();
   endtask

   task automatic test_junk();
      clear_counts();
      send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
      checks++;
      if (cmdValid !== 1'b0 || n_chk !== 0) begin
         failures++; $display("FAIL junk_silent: got valid=%b chkerr=%0d expected 0 0", cmdValid, n_chk);
      end
      send_range(PKT_A, 0, 9);
      checks++;
      if (cmdValid !== 1'b1 || w_cmd !== EXP_A) begin
         failures++; $display("FAIL junk_decode: got valid=%b cmd=%h expected 1 %h", cmdValid, w_cmd, EXP_A);
      end
      consume();
   endtask

   task automatic test_overrun();
      clear_counts();
      send_range(PKT_A, 0, 9);
      send_byte(8'h11); send_byte(8'hA5); send_byte(8'h22);
      @(negedge CLK);
      checks++;
      if (n_ovr !== 3) begin
         failures++; $display("FAIL overrun_count: got %0d expected 3", n_ovr);
      end
      checks++;
      if (cmdValid !== 1'b1 || w_cmd !== EXP_A) begin
         failures++; $display("FAIL overrun_hold: got valid=%b cmd=%h expected 1 %h", cmdValid, w_cmd, EXP_A);
      end
      cmdReady = 1'b1; rxData = 8'hA5; rxReady = 1'b1;
      @(negedge CLK);
      cmdReady = 1'b0; rxReady = 1'b0;
      checks++;
      if (cmdValid !== 1'b0) begin
         failures++; $display("FAIL overrun_handshake: got valid=%b expected 0", cmdValid);
      end
      send_range(PKT_B, 1, 9);
      checks++;
      if (cmdValid !== 1'b1 || w_cmd !== EXP_B) begin
         failures++; $display("FAIL overrun_new_pkt: got valid=%b cmd=%h expected 1 %h", cmdValid, w_cmd, EXP_B);
      end
      checks++;
      if (n_ovr !== 3 || n_rise !== 2) begin
         failures++; $display("FAIL overrun_after: got ovr=%0d rises=%0d expected 3 2", n_ovr, n_rise);
      end
      consume();
   endtask

   task automatic test_sync_in_payload();
      clear_counts();
      send_range(PKT_C, 0, 9);
      checks++;
      if (cmdValid !== 1'b1 || w_cmd !== EXP_C) begin
         failures++; $display("FAIL sync_payload: got valid=%b cmd=%h expected 1 %h", cmdValid, w_cmd, EXP_C);
      end
      consume();
   endtask

`ifdef UART_CMD_TIMEOUT_EN
   task automatic test_timeout();
      clear_counts();
      send_range(PKT_A, 0, 2);
      repeat (60) @(negedge CLK);
      checks++;
      if (n_to !== 1) begin
         failures++; $display("FAIL timeout_pulse: got %0d expected 1", n_to);
      end
      send_range(PKT_A, 0, 9);
      checks++;
      if (cmdValid !== 1'b1 || w_cmd !== EXP_A) begin
         failures++; $display("FAIL timeout_recover: got valid=%b cmd=%h expected 1 %h", cmdValid, w_cmd, EXP_A);
      end
      consume();
      clear_counts();
      send_range(PKT_A, 0, 2);
      repeat (48) @(negedge CLK);
      send_range(PKT_A, 3, 9);
      checks++;
      if (n_to !== 0 || cmdValid !== 1'b1 || w_cmd !== EXP_A) begin
         failures++; $display("FAIL timeout_edge_byte: got to=%0d valid=%b cmd=%h expected 0 1 %h", n_to, cmdValid, w_cmd, EXP_A);
      end
      consume();
   endtask
`endif

   task automatic test_reset_mid();
      send_range(PKT_A, 0, 9);
      consume();
      send_range(PKT_B, 0, 5);
      checks++;
      if (w_cmd !== EXP_A) begin
         failures++; $display("FAIL reset_mid_pre: got %h expected %h", w_cmd, EXP_A);
      end
      #2 RST = 1'b1;
      #1;
      checks++;
      if (w_cmd !== 51'd0 || cmdValid !== 1'b0) begin
         failures++; $display("FAIL reset_mid_async: got valid=%b cmd=%h expected 0 0", cmdValid, w_cmd);
      end
      @(negedge CLK);
      RST = 1'b0;
      clear_counts();
      send_range(PKT_B, 6, 9);
      repeat (2) @(negedge CLK);
      checks++;
      if (n_rise !== 0 || cmdValid !== 1'b0) begin
         failures++; $display("FAIL reset_mid_tail: got rises=%0d valid=%b expected 0 0", n_rise, cmdValid);
      end
      checks++;
      if (w_cmd !== 51'd0) begin
         failures++; $display("FAIL reset_mid_cmd: got %h expected 0", w_cmd);
      end
   endtask

   initial begin
      RST = 1'b0; rxData = 8'h00; rxReady = 1'b0; cmdReady = 1'b0;
      test_reset();
      test_good_packet();
      test_bad_checksum();
      test_junk();
      test_overrun();
      test_sync_in_payload();
`ifdef UART_CMD_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
